// File: rtl/ram_arb_pkg.sv
// Shared types and constants for the two-port RAM arbiter.
package ram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    CAPTURE = 2'd2,
    RESP    = 2'd3
  } state_t;

  localparam int   RAM_AW       = 8;
  localparam int   RAM_DW       = 32;
  localparam logic RAM_RW_WRITE = 1'b1;
  localparam logic RAM_RW_READ  = 1'b0;

endpackage

// File: rtl/ram_arb_pick.sv
// Combinational two-way grant. Macro RAM_ARB_ROUND_ROBIN_EN selects round-robin,
// otherwise port 0 has fixed priority. prio names the port favoured on a tie.
module ram_arb_pick (
  input  logic req0,
  input  logic req1,
  input  logic prio,
  output logic win
);

`ifdef RAM_ARB_ROUND_ROBIN_EN
  always_comb begin
    win = 1'b0;
    if (req0 && req1) begin
      win = prio;
    end else if (req1) begin
      win = 1'b1;
    end
  end
`else
  logic unused_prio;
  assign unused_prio = prio;

  always_comb begin
    win = 1'b0;
    if (req1 && !req0) begin
      win = 1'b1;
    end
  end
`endif

endmodule

// File: rtl/ram_port_arbiter.sv
// Two-port request/ack arbiter and sequencer for the 256x32 single-port RAM.
// Macro RAM_ARB_ROUND_ROBIN_EN enables the round-robin tie-break pointer.
import ram_arb_pkg::*;

module ram_port_arbiter #(
  parameter int AW = RAM_AW,
  parameter int DW = RAM_DW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0,
  input  logic          req1,
  input  logic          we0,
  input  logic          we1,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata0,
  input  logic [DW-1:0] wdata1,
  output logic          ack0,
  output logic          ack1,
  output logic [DW-1:0] rdata,
  output logic          busy,
  output logic [DW-1:0] ram_din,
  output logic [AW-1:0] ram_addr,
  output logic          ram_rw,
  input  logic [DW-1:0] ram_dout
);

  state_t        state_q;
  state_t        state_d;
  logic          win;
  logic          win_q;
  logic          we_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;
  logic [DW-1:0] rdata_q;
  logic          prio;
  logic          grant;

  assign grant = (state_q == IDLE) && (req0 || req1);

  ram_arb_pick u_pick (
    .req0 (req0),
    .req1 (req1),
    .prio (prio),
    .win  (win)
  );

`ifdef RAM_ARB_ROUND_ROBIN_EN
  logic prio_q;

  // After each grant the other port becomes the favoured one on the next tie.
  always_ff @(posedge clk) begin
    if (rst) begin
      prio_q <= 1'b0;
    end else if (grant) begin
      prio_q <= ~win;
    end
  end

  assign prio = prio_q;
`else
  assign prio = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (req0 || req1) state_d = ACCESS;
      ACCESS:  state_d = CAPTURE;
      CAPTURE: state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Grant stage: operands of the winner are frozen for the whole access.
  always_ff @(posedge clk) begin
    if (rst) begin
      win_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (grant) begin
      win_q   <= win;
      we_q    <= win ? we1    : we0;
      addr_q  <= win ? addr1  : addr0;
      wdata_q <= win ? wdata1 : wdata0;
    end
  end

  // Capture stage: RAM output is valid here because the RAM sampled at the end of ACCESS.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q <= '0;
    end else if (state_q == CAPTURE && !we_q) begin
      rdata_q <= ram_dout;
    end
  end

  // Reset gates ram_rw directly so a write in flight is never committed.
  always_comb begin
    ack0   = 1'b0;
    ack1   = 1'b0;
    busy   = (state_q != IDLE);
    ram_rw = RAM_RW_READ;
    if (state_q == RESP) begin
      ack0 = ~win_q;
      ack1 = win_q;
    end
    if (state_q == ACCESS && we_q && !rst) begin
      ram_rw = RAM_RW_WRITE;
    end
  end

  assign ram_addr = addr_q;
  assign ram_din  = wdata_q;
  assign rdata    = rdata_q;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed self-checking bench for ram_port_arbiter with a behavioural 256x32 RAM.
module tb_ram_port_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
  logic [7:0]  addr0 = '0, addr1 = '0;
  logic [31:0] wdata0 = '0, wdata1 = '0;
  logic        ack0, ack1, busy, ram_rw;
  logic [31:0] rdata, ram_din, ram_dout;
  logic [7:0]  ram_addr;

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] mem [256];

  always #5 clk = ~clk;

  ram_port_arbiter #(.AW(8), .DW(32)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .ack0(ack0), .ack1(ack1), .rdata(rdata), .busy(busy),
    .ram_din(ram_din), .ram_addr(ram_addr), .ram_rw(ram_rw), .ram_dout(ram_dout)
  );

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    ram_dout = 32'h0;
  end

  always @(posedge clk) begin
    if (ram_rw) mem[ram_addr] <= ram_din;
    ram_dout <= mem[ram_addr];
  end

  // Issues one access from IDLE and records latency, acking port, read data and
  // a per-cycle ram_rw trace (bit k-1 = cycle k). Returns in the following IDLE cycle.
  task automatic run_access(input logic port, input logic we, input logic [7:0] a,
                            input logic [31:0] wd, output int lat, output logic ap,
                            output logic [31:0] rd, output logic [7:0] rwmask);
    lat = -1; ap = 1'b0; rd = 32'hx; rwmask = '0;
    if (port) begin req1 = 1'b1; we1 = we; addr1 = a; wdata1 = wd; end
    else      begin req0 = 1'b1; we0 = we; addr0 = a; wdata0 = wd; end
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      rwmask[c-1] = ram_rw;
      if (ack0 || ack1) begin
        lat = c; ap = ack1; rd = rdata;
        break;
      end
    end
    req0 = 1'b0; req1 = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(negedge clk); @(negedge clk);
    vectors++;
    if ({busy, ack0, ack1, ram_rw} !== 4'b0000) begin
      miscompares++;
      $display("FAIL reset_ctrl busy/ack0/ack1/rw=%b expected 0000", {busy, ack0, ack1, ram_rw});
    end
    vectors++;
    if (ram_addr !== 8'h00 || ram_din !== 32'h0 || rdata !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_data addr=%h din=%h rdata=%h expected 0", ram_addr, ram_din, rdata);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_write_read();
    int lat; logic ap; logic [31:0] rd; logic [7:0] m;
    run_access(1'b0, 1'b1, 8'h05, 32'hDEADBEEF, lat, ap, rd, m);
    vectors++;
    if (lat !== 3 || ap !== 1'b0) begin
      miscompares++;
      $display("FAIL wr_latency lat=%0d port=%b expected 3 port 0", lat, ap);
    end
    vectors++;
    if (m !== 8'b0000_0001) begin
      miscompares++;
      $display("FAIL wr_rw_trace got %b expected 00000001", m);
    end
    run_access(1'b0, 1'b0, 8'h05, 32'h0, lat, ap, rd, m);
    vectors++;
    if (lat !== 3 || ap !== 1'b0 || rd !== 32'hDEADBEEF) begin
      miscompares++;
      $display("FAIL rd_05 lat=%0d port=%b rdata=%h expected 3 0 deadbeef", lat, ap, rd);
    end
    vectors++;
    if (m !== 8'b0) begin
      miscompares++;
      $display("FAIL rd_rw_trace got %b expected 00000000", m);
    end
  endtask

  task automatic test_bank_boundary();
    int lat; logic ap; logic [31:0] rd; logic [7:0] m;
    run_access(1'b1, 1'b1, 8'h3F, 32'h11111111, lat, ap, rd, m);
    run_access(1'b0, 1'b1, 8'h40, 32'h22222222, lat, ap, rd, m);
    vectors++;
    if (rdata !== 32'hDEADBEEF) begin
      miscompares++;
      $display("FAIL write_keeps_rdata got %h expected deadbeef", rdata);
    end
    run_access(1'b1, 1'b0, 8'h3F, 32'h0, lat, ap, rd, m);
    vectors++;
    if (lat !== 3 || ap !== 1'b1 || rd !== 32'h11111111) begin
      miscompares++;
      $display("FAIL rd_3f lat=%0d port=%b rdata=%h expected 3 1 11111111", lat, ap, rd);
    end
    run_access(1'b0, 1'b0, 8'h40, 32'h0, lat, ap, rd, m);
    vectors++;
    if (rd !== 32'h22222222) begin
      miscompares++;
      $display("FAIL rd_40 got %h expected 22222222", rd);
    end
    vectors++;
    if (ram_addr !== 8'h40 || rdata !== 32'h22222222) begin
      miscompares++;
      $display("FAIL hold_after_read addr=%h rdata=%h expected 40 22222222", ram_addr, rdata);
    end
  endtask

  task automatic test_tie();
    logic [3:0] got, exp;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
`ifdef RAM_ARB_ROUND_ROBIN_EN
    exp = 4'b1010;
`else
    exp = 4'b0000;
`endif
    got = 4'bxxxx;
    for (int r = 0; r < 4; r++) begin
      req0 = 1'b1; we0 = 1'b0; addr0 = 8'h05;
      req1 = 1'b1; we1 = 1'b0; addr1 = 8'h3F;
      for (int c = 0; c < 8; c++) begin
        @(negedge clk);
        if (ack0 || ack1) begin
          got[r] = ack1;
          break;
        end
      end
      req0 = 1'b0; req1 = 1'b0;
      @(negedge clk);
    end
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL tie_order winners(r3..r0)=%b expected %b", got, exp);
    end
  endtask

  task automatic test_busy_ignore();
    int t0, t1;
    t0 = -1; t1 = -1;
    req0 = 1'b1; we0 = 1'b0; addr0 = 8'h05;
    for (int c = 1; c <= 16; c++) begin
      @(negedge clk);
      if (c == 1) begin
        req1 = 1'b1; we1 = 1'b0; addr1 = 8'h40;
      end
      if (ack0 && ack1) t0 = -2;
      if (ack0 && t0 == -1) begin t0 = c; req0 = 1'b0; end
      if (ack1 && t1 == -1) begin t1 = c; req1 = 1'b0; break; end
    end
    req0 = 1'b0; req1 = 1'b0;
    @(negedge clk);
    vectors++;
    if (t0 !== 3) begin
      miscompares++;
      $display("FAIL busy_ack0 cycle=%0d expected 3", t0);
    end
    vectors++;
    if (t1 - t0 !== 4) begin
      miscompares++;
      $display("FAIL busy_ack1_gap got %0d expected 4", t1 - t0);
    end
    vectors++;
    if (rdata !== 32'h22222222) begin
      miscompares++;
      $display("FAIL busy_rdata got %h expected 22222222", rdata);
    end
  endtask

  task automatic test_reset_mid();
    int lat; logic ap; logic [31:0] rd; logic [7:0] m;
    logic rw_acc, rw_rst, anyack;
    req0 = 1'b1; we0 = 1'b1; addr0 = 8'hA0; wdata0 = 32'h12345678;
    @(negedge clk);
    rw_acc = ram_rw;
    rst = 1'b1;
    req0 = 1'b0;
    #1 rw_rst = ram_rw;
    vectors++;
    if (rw_acc !== 1'b1 || rw_rst !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_rw access=%b in_reset=%b expected 1 0", rw_acc, rw_rst);
    end
    @(negedge clk);
    rst = 1'b0;
    anyack = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      anyack = anyack | ack0 | ack1 | busy;
    end
    vectors++;
    if (anyack !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_no_ack saw ack/busy=%b expected 0", anyack);
    end
    run_access(1'b1, 1'b0, 8'hA0, 32'h0, lat, ap, rd, m);
    vectors++;
    if (lat !== 3 || rd !== 32'h0) begin
      miscompares++;
      $display("FAIL rst_rd_a0 lat=%0d rdata=%h expected 3 00000000", lat, rd);
    end
  endtask

  task automatic test_idle();
    logic seen;
    seen = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      seen = seen | ram_rw | busy | ack0 | ack1;
    end
    vectors++;
    if (seen !== 1'b0) begin
      miscompares++;
      $display("FAIL idle_quiet activity=%b expected 0", seen);
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_bank_boundary();
    test_tie();
    test_busy_ignore();
    test_reset_mid();
    test_idle();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
